fp_mul: RTL and testbench

- Byte-serial IEEE-754 double-precision (binary64) multiplier.
- Takes two 64-bit operands as 16 bytes over an 8-bit input port and computes Z = A × B with round-to-nearest-even.
- Streams the 64-bit result back as 8 bytes, framed by READY.
- Sits behind a narrow 8-bit bus as a self-contained arithmetic slave.

---
 rtl/fp_mul.sv | 174 +++++++++++++++++
 tb/tb_fp_mul.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/fp_mul.sv
// Byte-serial binary64 multiplier. Operands arrive as 16 bytes (A then B, each LSB first)
// over an 8-bit port, a two-cycle datapath forms the RNE product, and the 64-bit result
// streams back MSB first while READY is high. Subnormal inputs read as zero, and
// underflowing results flush to zero.
module fp_mul (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       ENABLE,
  input  logic [7:0] DATA_IN,
  output logic [7:0] DATA_OUT,
  output logic       READY
);

  typedef enum logic [1:0] {StLoad, StCalc1, StCalc2, StOut} state_e;

  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  // Byte 0 ends up in [7:0]: bytes shift in at the top.
  logic [127:0] op_q;
  logic [63:0]  res_q;
  logic         ready_q, ready_d;
  logic [7:0]   dout_q, dout_d;

  // Stage-1 results, held for stage 2.
  logic                sign_q, nan_q, inf_q, zero_q;
  logic signed [12:0]  exp_q;
  logic [105:0]        prod_q;

  // Stage 1: unpack, classify, multiply significands
  logic [10:0]        ea, eb;
  logic [51:0]        fa, fb;
  logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic               sign_d, nan_d, inf_d, zero_d;
  logic signed [12:0] exp_d;
  logic [105:0]       ma_ext, mb_ext, prod_d;

  // Stage 1 combinational unpack and significand product
  always_comb begin
    ea     = op_q[62:52];
    fa     = op_q[51:0];
    eb     = op_q[126:116];
    fb     = op_q[115:64];
    a_nan  = (&ea) & (|fa);
    b_nan  = (&eb) & (|fb);
    a_inf  = (&ea) & ~(|fa);
    b_inf  = (&eb) & ~(|fb);
    a_zero = ~(|ea);
    b_zero = ~(|eb);
    sign_d = op_q[63] ^ op_q[127];
    nan_d  = a_nan | b_nan | (a_inf & b_zero) | (a_zero & b_inf);
    inf_d  = a_inf | b_inf;
    zero_d = a_zero | b_zero;
    exp_d  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 13'sd1023;
    ma_ext = {53'd0, 1'b1, fa};
    mb_ext = {53'd0, 1'b1, fb};
    prod_d = ma_ext * mb_ext;
  end

  // Stage 2: normalise, round to nearest even, pack
  logic [105:0]       norm;
  logic signed [12:0] exp_n, exp_r;
  logic [52:0]        keep;
  logic               guard, rnd, sticky, rnd_up;
  logic [53:0]        mant;
  logic [51:0]        frac;
  logic [63:0]        z_d;

  // Stage 2 combinational normalise/round/pack with special-case override
  always_comb begin
    norm   = prod_q[105] ? prod_q : (prod_q << 1);
    exp_n  = exp_q + $signed({12'd0, prod_q[105]});
    keep   = norm[105:53];
    guard  = norm[52];
    rnd    = norm[51];
    sticky = |norm[50:0];
    rnd_up = guard & (rnd | sticky | keep[0]);
    mant   = {1'b0, keep} + {53'd0, rnd_up};
    // Carry out of rounding leaves an all-zero fraction one binade up.
    exp_r  = exp_n + $signed({12'd0, mant[53]});
    frac   = mant[53] ? mant[52:1] : mant[51:0];
    if (nan_q) begin
      z_d = 64'h7FF8_0000_0000_0000;
    end else if (inf_q || exp_r >= 13'sd2047) begin
      z_d = {sign_q, 11'h7FF, 52'd0};
    end else if (zero_q || exp_r <= 13'sd0) begin
      z_d = {sign_q, 63'd0};
    end else begin
      z_d = {sign_q, exp_r[10:0], frac};
    end
  end

  // Sequencer next-state, byte counter and registered output values
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = 1'b0;
    dout_d  = 8'h00;
    unique case (state_q)
      StLoad: begin
        if (ENABLE) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            cnt_d   = 4'd0;
            state_d = StCalc1;
          end
        end
      end
      StCalc1: state_d = StCalc2;
      StCalc2: state_d = StOut;
      StOut: begin
        if (cnt_q == 4'd8) begin
          cnt_d   = 4'd0;
          state_d = StLoad;
        end else begin
          cnt_d   = cnt_q + 4'd1;
          ready_d = 1'b1;
          dout_d  = res_q[63:56];
        end
      end
      default: state_d = StLoad;
    endcase
  end

  // Control state register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= StLoad;
      cnt_q   <= 4'd0;
      ready_q <= 1'b0;
      dout_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      dout_q  <= dout_d;
    end
  end

  // Operand capture, pipeline stages and result shift register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      op_q   <= '0;
      res_q  <= '0;
      sign_q <= 1'b0;
      nan_q  <= 1'b0;
      inf_q  <= 1'b0;
      zero_q <= 1'b0;
      exp_q  <= '0;
      prod_q <= '0;
    end else begin
      if (state_q == StLoad && ENABLE) begin
        op_q <= {DATA_IN, op_q[127:8]};
      end
      if (state_q == StCalc1) begin
        sign_q <= sign_d;
        nan_q  <= nan_d;
        inf_q  <= inf_d;
        zero_q <= zero_d;
        exp_q  <= exp_d;
        prod_q <= prod_d;
      end
      if (state_q == StCalc2) begin
        res_q <= z_d;
      end else if (state_q == StOut && cnt_q != 4'd8) begin
        res_q <= {res_q[55:0], 8'h00};
      end
    end
  end

  assign READY    = ready_q;
  assign DATA_OUT = dout_q;

endmodule

// File: tb/tb_fp_mul.sv
// Bench for fp_mul: directed cases plus random ratios against a real-arithmetic model.
module tb_fp_mul;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       ENABLE = 1'b0;
  logic [7:0] DATA_IN = 8'h00;
  logic [7:0] DATA_OUT;
  logic       READY;

  int n_cmp = 0;
  int n_bad = 0;

  fp_mul dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .ENABLE   (ENABLE),
    .DATA_IN  (DATA_IN),
    .DATA_OUT (DATA_OUT),
    .READY    (READY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  // Reference: classify by the block's rules, then use native double multiply.
  function automatic logic [63:0] ref_mul(input logic [63:0] a, input logic [63:0] b);
    logic        s;
    logic        an, bn, ai, bi, az, bz;
    logic [63:0] r;
    s  = a[63] ^ b[63];
    an = (a[62:52] == 11'h7FF) && (a[51:0] != 0);
    bn = (b[62:52] == 11'h7FF) && (b[51:0] != 0);
    ai = (a[62:52] == 11'h7FF) && (a[51:0] == 0);
    bi = (b[62:52] == 11'h7FF) && (b[51:0] == 0);
    az = (a[62:52] == 11'h000);
    bz = (b[62:52] == 11'h000);
    if (an || bn || (ai && bz) || (az && bi)) return 64'h7FF8_0000_0000_0000;
    if (ai || bi) return {s, 11'h7FF, 52'd0};
    if (az || bz) return {s, 63'd0};
    r = $realtobits($bitstoreal(a) * $bitstoreal(b));
    if (r[62:52] == 11'h000) return {s, 63'd0};
    return r;
  endfunction

  task automatic send_bytes(input logic [63:0] a, input logic [63:0] b, input int n,
                            input int gap_at, input int gap_len);
    logic [127:0] stream;
    stream = {b, a};
    for (int i = 0; i < n; i++) begin
      if (i == gap_at) begin
        repeat (gap_len) begin
          @(negedge CLK);
          ENABLE  = 1'b0;
          DATA_IN = 8'hA5;
        end
      end
      @(negedge CLK);
      ENABLE  = 1'b1;
      DATA_IN = stream[8*i +: 8];
    end
  endtask

  // Waits for the result (driving ignored junk meanwhile), checks framing, returns Z.
  task automatic collect(input string tag, output logic [63:0] z);
    int lat;
    @(negedge CLK);
    ENABLE  = 1'b1;
    DATA_IN = 8'($urandom);
    lat = 1;
    while (!READY && lat < 20) begin
      @(negedge CLK);
      DATA_IN = 8'($urandom);
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'd4);
    z = '0;
    for (int i = 0; i < 8; i++) begin
      chk({tag, "_ready_hi"}, 64'(READY), 64'd1);
      z = {z[55:0], DATA_OUT};
      @(negedge CLK);
      DATA_IN = 8'($urandom);
    end
    ENABLE = 1'b0;
    chk({tag, "_ready_lo"}, 64'(READY), 64'd0);
    chk({tag, "_dout_idle"}, 64'(DATA_OUT), 64'd0);
  endtask

  task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] want, input int gap_at, input int gap_len);
    logic [63:0] z;
    send_bytes(a, b, 16, gap_at, gap_len);
    collect(tag, z);
    chk(tag, z, want);
  endtask

  initial begin
    logic [63:0] a, b, tiny;
    int          xs, ys;
    int          wait_n;
    real         ra, rb;

    repeat (3) @(negedge CLK);
    chk("rst_ready", 64'(READY), 64'd0);
    chk("rst_dout", 64'(DATA_OUT), 64'd0);
    RESET = 1'b1;

    run_op("one_x_one", 64'h3FF0_0000_0000_0000, 64'h3FF0_0000_0000_0000,
           64'h3FF0_0000_0000_0000, -1, 0);
    run_op("two_x_m3", 64'h4000_0000_0000_0000, 64'hC008_0000_0000_0000,
           64'hC018_0000_0000_0000, -1, 0);
    run_op("gap_1p5sq", 64'h3FF8_0000_0000_0000, 64'h3FF8_0000_0000_0000,
           64'h4002_0000_0000_0000, 5, 3);
    run_op("rne_lsb", 64'h3FF0_0000_0000_0001, 64'h3FF0_0000_0000_0001,
           64'h3FF0_0000_0000_0002, -1, 0);
    run_op("rnd_carry", 64'h3FF0_0000_0000_0001, 64'h3FFF_FFFF_FFFF_FFFF,
           64'h4000_0000_0000_0000, -1, 0);
    run_op("zero_x_m5", 64'h0000_0000_0000_0000, 64'hC014_0000_0000_0000,
           64'h8000_0000_0000_0000, -1, 0);
    run_op("inf_x_zero", 64'h7FF0_0000_0000_0000, 64'h0000_0000_0000_0000,
           64'h7FF8_0000_0000_0000, -1, 0);
    run_op("overflow", 64'h6974_E718_D7D7_625A, 64'h6974_E718_D7D7_625A,
           64'h7FF0_0000_0000_0000, -1, 0);
    tiny = $realtobits(1.0e-200);
    run_op("underflow", tiny, tiny, 64'h0000_0000_0000_0000, -1, 0);
    run_op("nan_in", 64'h7FF0_0000_0000_0001, 64'h3FF0_0000_0000_0000,
           64'h7FF8_0000_0000_0000, -1, 0);
    run_op("m_inf_x_2", 64'hFFF0_0000_0000_0000, 64'h4000_0000_0000_0000,
           64'hFFF0_0000_0000_0000, -1, 0);

    // Abort after 10 bytes; the next operation must start from byte 0.
    send_bytes(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 10, -1, 0);
    #2 RESET = 1'b0;
    #1;
    chk("rst_mid_ready", 64'(READY), 64'd0);
    chk("rst_mid_dout", 64'(DATA_OUT), 64'd0);
    @(negedge CLK);
    ENABLE = 1'b0;
    RESET  = 1'b1;
    run_op("after_rst", 64'h4000_0000_0000_0000, 64'h4010_0000_0000_0000,
           64'h4020_0000_0000_0000, -1, 0);

    // Abort while the result is being streamed out.
    send_bytes(64'h3FF8_0000_0000_0000, 64'hBFF0_0000_0000_0000, 16, -1, 0);
    @(negedge CLK);
    ENABLE = 1'b0;
    wait_n = 0;
    while (!READY && wait_n < 20) begin
      @(negedge CLK);
      wait_n++;
    end
    chk("out_started", 64'(READY), 64'd1);
    @(negedge CLK);
    #2 RESET = 1'b0;
    #1;
    chk("rst_out_ready", 64'(READY), 64'd0);
    chk("rst_out_dout", 64'(DATA_OUT), 64'd0);
    @(negedge CLK);
    RESET = 1'b1;
    run_op("after_rst2", 64'h3FF8_0000_0000_0000, 64'h3FF8_0000_0000_0000,
           64'h4002_0000_0000_0000, -1, 0);

    for (int k = 0; k < 200; k++) begin
      xs = int'($urandom);
      ys = int'($urandom);
      if (ys == 0) ys = 1;
      ra = real'(xs) / real'(ys);
      xs = int'($urandom);
      ys = int'($urandom);
      if (ys == 0) ys = 7;
      rb = real'(xs) / real'(ys);
      a = $realtobits(ra);
      b = $realtobits(rb);
      run_op("rand", a, b, ref_mul(a, b), (k % 4 == 0) ? int'($urandom_range(1, 15)) : -1,
             int'($urandom_range(1, 4)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
